ps2_rx: RTL and testbench

PS/2 keyboard receiver feeding the I/O bridge's keyboard register. It samples the raw `ps2_clk`/`ps2_data` lines and filters clock glitches. It deframes 11-bit device-to-host frames, checks parity and stop bit, and queues good scancodes in a FIFO. The bridge pops them on read and uses `irq` to raise the CPU interrupt.

---
 rtl/ps2_rx.sv | 179 +++++++++++++++++
 tb/tb_ps2_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit deframing, scancode FIFO (FWFT).
// Fall edge 2+FILTER_LEN cycles after raw; byte visible 1 cycle after stop edge; FIFO full drops the byte.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rd,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   count,
  output logic               irq,
  output logic               err_parity,
  output logic               err_frame,
  output logic               err_overflow,
  input  logic               err_clear
);

  localparam int FCW   = $clog2(FILTER_LEN + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic           filt_clk_q, filt_clk_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     sr_q, sr_d;
  logic           par_ok_q, par_ok_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           tmo_hit;
  logic           push_vld, set_par, set_frm;

  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic             empty, full, do_pop, do_push, ovf_set;
  logic             err_par_q, err_par_d, err_frm_q, err_frm_d, err_ovf_q, err_ovf_d;

  // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s2_q;
        fall       = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign tmo_hit = (state_q != IDLE) && (tmo_q == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fall) begin
      case (state_q)
        IDLE:    if (!dat_s2_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    push_vld = fall && (state_q == STOP) && dat_s2_q && par_ok_q;
    set_par  = fall && (state_q == STOP) && !par_ok_q;
    set_frm  = (fall && (state_q == STOP) && !dat_s2_q) || (tmo_hit && !fall);
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_ok_d  = par_ok_q;
    tmo_d     = tmo_q + 1'b1;
    if ((state_q == IDLE) || fall || tmo_hit) tmo_d = '0;
    if (fall) begin
      case (state_q)
        IDLE:   bit_cnt_d = '0;
        DATA: begin
          sr_d      = {dat_s2_q, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: par_ok_d = ^{sr_q, dat_s2_q};
        default: ;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
              (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    do_pop  = rd && !empty;
    do_push = push_vld && (!full || do_pop);
    ovf_set = push_vld && full && !do_pop;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_ptr_q[FIFO_AW-1:0]] = sr_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    err_par_d = set_par ? 1'b1 : (err_clear ? 1'b0 : err_par_q);
    err_frm_d = set_frm ? 1'b1 : (err_clear ? 1'b0 : err_frm_q);
    err_ovf_d = ovf_set ? 1'b1 : (err_clear ? 1'b0 : err_ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      par_ok_q   <= 1'b0;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      par_ok_q   <= par_ok_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data      = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign rd_valid     = !empty;
  assign irq          = !empty;
  assign count        = wr_ptr_q - rd_ptr_q;
  assign err_parity   = err_par_q;
  assign err_frame    = err_frm_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed PS/2 frames against a byte-queue model checked every cycle.
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int AW   = 3;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd = 1'b0;
  logic        err_clear = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [AW:0] count;
  logic        irq, err_parity, err_frame, err_overflow;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .irq(irq),
    .err_parity(err_parity), .err_frame(err_frame), .err_overflow(err_overflow),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // Model state, written only by the stimulus process.
  logic [7:0] mq [$];
  bit         m_par = 0, m_frm = 0, m_ovf = 0;
  bit         chk_en = 0;

  // Literal expectations handed to the compare process.
  int         lit_req = 0, lit_ack = 0;
  string      lit_name;
  logic [7:0] lit_data;
  int         lit_count;
  bit         lit_perr, lit_ferr, lit_oerr;

  int checks = 0, failures = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_data",  rd_data, (mq.size() != 0) ? int'(mq[0]) : 0);
      cmp("m_count", count, mq.size());
      cmp("m_valid", rd_valid, mq.size() != 0);
      cmp("m_irq",   irq, mq.size() != 0);
      cmp("m_perr",  err_parity, m_par);
      cmp("m_ferr",  err_frame, m_frm);
      cmp("m_oerr",  err_overflow, m_ovf);
    end
    if (lit_req != lit_ack) begin
      cmp({lit_name, "_data"},  rd_data, lit_data);
      cmp({lit_name, "_count"}, count, lit_count);
      cmp({lit_name, "_irq"},   irq, lit_count != 0);
      cmp({lit_name, "_perr"},  err_parity, lit_perr);
      cmp({lit_name, "_ferr"},  err_frame, lit_ferr);
      cmp({lit_name, "_oerr"},  err_overflow, lit_oerr);
      lit_ack = lit_req;
    end
  end

  task automatic expect_lit(input string name, input logic [7:0] d, input int c,
                            input bit pe, input bit fe, input bit oe);
    lit_name = name; lit_data = d; lit_count = c;
    lit_perr = pe; lit_ferr = fe; lit_oerr = oe;
    lit_req++;
    @(negedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // Full frame; optionally pulse rd so it is sampled on the stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit pop);
    bit par_good;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_data = s;
    wait_cyc(HALF);
    chk_en  = 0;
    ps2_clk = 1'b0;
    if (pop) begin
      wait_cyc(FL + 1);
      rd = 1'b1;
      wait_cyc(1);
      rd = 1'b0;
      wait_cyc(HALF - FL - 2);
    end else begin
      wait_cyc(HALF);
    end
    par_good = ((^d) ^ p) == 1'b1;
    if (s && par_good) begin
      if (pop && mq.size() != 0) begin
        void'(mq.pop_front());
        mq.push_back(d);
      end else if (mq.size() < (1 << AW)) mq.push_back(d);
      else m_ovf = 1;
    end else begin
      if (!par_good) m_par = 1;
      if (!s) m_frm = 1;
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    chk_en   = 1;
    wait_cyc(HALF);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1, 0);
  endtask

  task automatic pop1();
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    err_clear = 1'b1;
    wait_cyc(1);
    err_clear = 1'b0;
    m_par = 0; m_frm = 0; m_ovf = 0;
  endtask

  initial begin
    logic [7:0] exp_b;
    logic [7:0] d77;
    wait_cyc(3);
    rst_n  = 1'b1;
    chk_en = 1;
    expect_lit("reset", 8'h00, 0, 0, 0, 0);

    send(8'h1C);
    expect_lit("good1c", 8'h1C, 1, 0, 0, 0);
    pop1();
    expect_lit("pop1c", 8'h00, 0, 0, 0, 0);

    send_frame(8'hF0, 1'b0, 1'b1, 0);
    expect_lit("badpar", 8'h00, 0, 1, 0, 0);
    clear_flags();
    expect_lit("clr1", 8'h00, 0, 0, 0, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    expect_lit("badstop", 8'h00, 0, 0, 1, 0);
    clear_flags();

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    chk_en = 0;
    wait_cyc(TO + 10);
    m_frm  = 1;
    chk_en = 1;
    expect_lit("timeout", 8'h00, 0, 0, 1, 0);
    clear_flags();
    send(8'h29);
    expect_lit("after_to", 8'h29, 1, 0, 0, 0);
    pop1();

    for (int i = 1; i <= 9; i++) send(8'(i));
    expect_lit("overflow", 8'h01, 8, 0, 0, 1);
    clear_flags();
    send_frame(8'hAA, ~^8'hAA, 1'b1, 1);
    expect_lit("pushpop_full", 8'h02, 8, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(i + 2) : 8'hAA;
      expect_lit("drain", exp_b, 8 - i, 0, 0, 0);
      pop1();
    end
    expect_lit("drained", 8'h00, 0, 0, 0, 0);

    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(3);
    ps2_clk  = 1'b1;
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    expect_lit("glitch", 8'h00, 0, 0, 0, 0);
    send(8'h33);
    expect_lit("post_glitch", 8'h33, 1, 0, 0, 0);
    pop1();

    send(8'h11);
    send(8'h22);
    expect_lit("two_queued", 8'h11, 2, 0, 0, 0);
    d77 = 8'h77;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(d77[i]);
    rst_n = 1'b0;
    mq.delete();
    m_par = 0; m_frm = 0; m_ovf = 0;
    wait_cyc(4);
    expect_lit("in_reset", 8'h00, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_cyc(2);
    expect_lit("post_reset", 8'h00, 0, 0, 0, 0);
    send(8'h12);
    expect_lit("after_rst", 8'h12, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
